// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencer and the five datapath stages.
// The master side is the sequencer; the slave side is the stage datapath that reports status.
interface pipe_ctrl_if #(
  parameter int CNT_WIDTH    = 16,
  parameter int REG_ID_WIDTH = 5
) ();
  logic                    i_ifu_valid;
  logic                    i_idu_rs1_en;
  logic                    i_idu_rs2_en;
  logic [REG_ID_WIDTH-1:0] i_idu_rs1_id;
  logic [REG_ID_WIDTH-1:0] i_idu_rs2_id;
  logic                    i_exu_load;
  logic [REG_ID_WIDTH-1:0] i_exu_rd_id;
  logic                    i_exu_jmp_en;
  logic                    i_lsu_busy;

  logic                    o_pc_we;
  logic                    o_pc_sel_jmp;
  logic                    o_i2i_en;
  logic                    o_i2e_en;
  logic                    o_e2l_en;
  logic                    o_l2w_en;
  logic                    o_idu_valid;
  logic                    o_exu_valid;
  logic                    o_lsu_valid;
  logic                    o_wbu_valid;
  logic [CNT_WIDTH-1:0]    o_stall_cnt;
  logic [CNT_WIDTH-1:0]    o_flush_cnt;

  modport master (
    input  i_ifu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_id, i_idu_rs2_id,
           i_exu_load, i_exu_rd_id, i_exu_jmp_en, i_lsu_busy,
    output o_pc_we, o_pc_sel_jmp, o_i2i_en, o_i2e_en, o_e2l_en, o_l2w_en,
           o_idu_valid, o_exu_valid, o_lsu_valid, o_wbu_valid,
           o_stall_cnt, o_flush_cnt
  );

  modport slave (
    output i_ifu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_id, i_idu_rs2_id,
           i_exu_load, i_exu_rd_id, i_exu_jmp_en, i_lsu_busy,
    input  o_pc_we, o_pc_sel_jmp, o_i2i_en, o_i2e_en, o_e2l_en, o_l2w_en,
           o_idu_valid, o_exu_valid, o_lsu_valid, o_wbu_valid,
           o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: per-stage valid tracking, inter-stage load enables,
// and freeze / flush / load-use hazard resolution with saturating performance counters.
module pipe_ctrl #(
  parameter int CNT_WIDTH    = 16,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic         i_sys_clk,
  input  logic         i_sys_rst,
  pipe_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_HAZARD = 2'd1,
    MODE_FLUSH  = 2'd2,
    MODE_FREEZE = 2'd3
  } mode_t;

  logic                 v_idu, v_exu, v_lsu, v_wbu;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

  logic                 freeze, flush, hazard;
  logic                 rs1_hit, rs2_hit;
  mode_t                mode;

  logic                 pc_we, pc_sel_jmp, i2i_en, i2e_en, e2l_en, l2w_en;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Event decode from current state and stage status
  always_comb begin
    rs1_hit = bus.i_idu_rs1_en && (bus.i_idu_rs1_id == bus.i_exu_rd_id);
    rs2_hit = bus.i_idu_rs2_en && (bus.i_idu_rs2_id == bus.i_exu_rd_id);
    freeze  = v_lsu && bus.i_lsu_busy;
    flush   = v_exu && bus.i_exu_jmp_en;
    // x0 is hardwired, so a load targeting it can never feed a dependent read
    hazard  = v_idu && v_exu && bus.i_exu_load &&
              (bus.i_exu_rd_id != {REG_ID_WIDTH{1'b0}}) && (rs1_hit || rs2_hit);

    if (freeze)      mode = MODE_FREEZE;
    else if (flush)  mode = MODE_FLUSH;
    else if (hazard) mode = MODE_HAZARD;
    else             mode = MODE_RUN;
  end

  // Enable generation; reset gates everything low without waiting for a clock
  always_comb begin
    pc_we      = 1'b0;
    pc_sel_jmp = 1'b0;
    i2i_en     = 1'b0;
    i2e_en     = 1'b0;
    e2l_en     = 1'b0;
    l2w_en     = 1'b0;
    if (!i_sys_rst) begin
      unique case (mode)
        MODE_FREEZE: ;
        MODE_FLUSH: begin
          pc_we      = 1'b1;
          pc_sel_jmp = 1'b1;
          i2i_en     = 1'b1;
          i2e_en     = 1'b1;
          e2l_en     = 1'b1;
          l2w_en     = 1'b1;
        end
        MODE_HAZARD: begin
          e2l_en = 1'b1;
          l2w_en = 1'b1;
        end
        default: begin
          pc_we  = bus.i_ifu_valid;
          i2i_en = 1'b1;
          i2e_en = 1'b1;
          e2l_en = 1'b1;
          l2w_en = 1'b1;
        end
      endcase
    end
  end

  // Valid bits advance by mode
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      v_idu <= 1'b0;
      v_exu <= 1'b0;
      v_lsu <= 1'b0;
      v_wbu <= 1'b0;
    end else begin
      unique case (mode)
        MODE_FREEZE: begin
          v_wbu <= 1'b0;
        end
        MODE_FLUSH: begin
          v_idu <= 1'b0;
          v_exu <= 1'b0;
          v_lsu <= 1'b1;
          v_wbu <= v_lsu;
        end
        MODE_HAZARD: begin
          v_exu <= 1'b0;
          v_lsu <= v_exu;
          v_wbu <= v_lsu;
        end
        default: begin
          v_idu <= bus.i_ifu_valid;
          v_exu <= v_idu;
          v_lsu <= v_exu;
          v_wbu <= v_lsu;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mode == MODE_FREEZE || mode == MODE_HAZARD) stall_cnt <= sat_inc(stall_cnt);
      if (mode == MODE_FLUSH)                         flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign bus.o_pc_we      = pc_we;
  assign bus.o_pc_sel_jmp = pc_sel_jmp;
  assign bus.o_i2i_en     = i2i_en;
  assign bus.o_i2e_en     = i2e_en;
  assign bus.o_e2l_en     = e2l_en;
  assign bus.o_l2w_en     = l2w_en;
  assign bus.o_idu_valid  = v_idu;
  assign bus.o_exu_valid  = v_exu;
  assign bus.o_lsu_valid  = v_lsu;
  assign bus.o_wbu_valid  = v_wbu;
  assign bus.o_stall_cnt  = stall_cnt;
  assign bus.o_flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model predicts enables each cycle and
// queues the expected registered state, which is compared after the following clock edge.
module tb_pipe_ctrl;

  localparam int CW = 16;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_WIDTH(CW), .REG_ID_WIDTH(RW)) bus ();

  pipe_ctrl #(.CNT_WIDTH(CW), .REG_ID_WIDTH(RW)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic          vi, ve, vl, vw;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  logic          m_vi, m_ve, m_vl, m_vw;
  logic [CW-1:0] m_sc, m_fc;
  logic [CW-1:0] fc_before;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_vi = 0; m_ve = 0; m_vl = 0; m_vw = 0; m_sc = '0; m_fc = '0;
    sb_q.delete();
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1;
  endfunction

  // One clock cycle: drive at posedge+1, check enables at negedge, check state after next posedge
  task automatic step(input logic ifu, input logic r1e, input logic [RW-1:0] r1,
                      input logic r2e, input logic [RW-1:0] r2, input logic ld,
                      input logic [RW-1:0] rd, input logic jmp, input logic busy);
    logic fz, fl, hz;
    logic [5:0] en_exp;
    exp_t e, got_e;
    bus.i_ifu_valid  = ifu;
    bus.i_idu_rs1_en = r1e; bus.i_idu_rs1_id = r1;
    bus.i_idu_rs2_en = r2e; bus.i_idu_rs2_id = r2;
    bus.i_exu_load   = ld;  bus.i_exu_rd_id  = rd;
    bus.i_exu_jmp_en = jmp; bus.i_lsu_busy   = busy;

    fz = m_vl & busy;
    fl = m_ve & jmp;
    hz = m_vi & m_ve & ld & (rd != 0) & ((r1e & (r1 == rd)) | (r2e & (r2 == rd)));
    e = '{vi: m_vi, ve: m_ve, vl: m_vl, vw: m_vw, sc: m_sc, fc: m_fc};
    if (fz) begin
      en_exp = 6'b000000;
      e.vw = 0; e.sc = sat(m_sc);
    end else if (fl) begin
      en_exp = 6'b111111;
      e.vi = 0; e.ve = 0; e.vl = 1; e.vw = m_vl; e.fc = sat(m_fc);
    end else if (hz) begin
      en_exp = 6'b000011;
      e.ve = 0; e.vl = m_ve; e.vw = m_vl; e.sc = sat(m_sc);
    end else begin
      en_exp = {ifu, 5'b01111};
      e.vi = ifu; e.ve = m_vi; e.vl = m_ve; e.vw = m_vl;
    end
    sb_q.push_back(e);

    @(negedge clk);
    check("enables", {26'd0, bus.o_pc_we, bus.o_pc_sel_jmp, bus.o_i2i_en, bus.o_i2e_en,
                      bus.o_e2l_en, bus.o_l2w_en}, {26'd0, en_exp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got_e = '{vi: bus.o_idu_valid, ve: bus.o_exu_valid, vl: bus.o_lsu_valid,
              vw: bus.o_wbu_valid, sc: bus.o_stall_cnt, fc: bus.o_flush_cnt};
    check("valids", {28'd0, got_e.vi, got_e.ve, got_e.vl, got_e.vw},
                    {28'd0, e.vi, e.ve, e.vl, e.vw});
    check("stall_cnt", {16'd0, got_e.sc}, {16'd0, e.sc});
    check("flush_cnt", {16'd0, got_e.fc}, {16'd0, e.fc});
    m_vi = e.vi; m_ve = e.ve; m_vl = e.vl; m_vw = e.vw; m_sc = e.sc; m_fc = e.fc;
  endtask

  task automatic run(input logic ifu);
    step(ifu, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.i_ifu_valid = 1; bus.i_idu_rs1_en = 0; bus.i_idu_rs2_en = 0;
    bus.i_idu_rs1_id = 0; bus.i_idu_rs2_id = 0; bus.i_exu_load = 0;
    bus.i_exu_rd_id = 0; bus.i_exu_jmp_en = 0; bus.i_lsu_busy = 0;
    model_reset();

    // Reset state, with a fetch pending to show enables are gated
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {28'd0, bus.o_idu_valid, bus.o_exu_valid, bus.o_lsu_valid, bus.o_wbu_valid}, 32'd0);
    check("rst_pc_we", {31'd0, bus.o_pc_we}, 32'd0);
    check("rst_en", {28'd0, bus.o_i2i_en, bus.o_i2e_en, bus.o_e2l_en, bus.o_l2w_en}, 32'd0);
    check("rst_cnt", {bus.o_stall_cnt, bus.o_flush_cnt}, 32'd0);
    rst = 1'b0;

    // Fill
    for (int i = 0; i < 4; i++) run(1);
    check("fill_wbu", {31'd0, bus.o_wbu_valid}, 32'd1);
    check("fill_cnts", {bus.o_stall_cnt, bus.o_flush_cnt}, 32'd0);

    // Load-use on rs1
    step(1, 1, 5, 0, 0, 1, 5, 0, 0);
    check("haz_exu_bubble", {31'd0, bus.o_exu_valid}, 32'd0);
    check("haz_stall_cnt", {16'd0, bus.o_stall_cnt}, 32'd1);
    run(1);
    // rd = 0, rs1 disabled match, and rs2 hit
    step(1, 1, 0, 0, 0, 1, 0, 0, 0);
    check("rd0_no_stall", {16'd0, bus.o_stall_cnt}, 32'd1);
    step(1, 0, 7, 0, 0, 1, 7, 0, 0);
    step(1, 0, 0, 1, 9, 1, 9, 0, 0);
    check("rs2_haz_stall", {16'd0, bus.o_stall_cnt}, 32'd2);
    run(1);

    // Taken jump, also colliding with a hazard
    step(1, 1, 3, 0, 0, 1, 3, 1, 0);
    check("flush_valids", {29'd0, bus.o_idu_valid, bus.o_exu_valid, bus.o_lsu_valid}, 32'd1);
    check("flush_cnt1", {16'd0, bus.o_flush_cnt}, 32'd1);

    // LSU freeze for three cycles
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("freeze_stall", {16'd0, bus.o_stall_cnt}, 32'd5);
    check("freeze_lsu_hold", {31'd0, bus.o_lsu_valid}, 32'd1);

    // Busy with v_lsu = 0 is ignored
    run(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1);

    // Freeze beats flush; flush taken once busy drops
    fc_before = m_fc;
    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    run(1);
    check("prio_one_flush", {16'd0, bus.o_flush_cnt}, {16'd0, fc_before + 16'd1});

    // Long freeze to saturate the stall counter
    run(1); run(1);
    check("sat_pre_lsu", {31'd0, bus.o_lsu_valid}, 32'd1);
    bus.i_lsu_busy = 1'b1;
    repeat (66000) @(posedge clk);
    #1;
    m_sc = {CW{1'b1}}; m_vw = 1'b0;
    check("sat_stall", {16'd0, bus.o_stall_cnt}, 32'h0000FFFF);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    run(1);

    // Asynchronous reset between edges
    bus.i_ifu_valid = 1'b1; bus.i_lsu_busy = 1'b0; bus.i_exu_jmp_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valids", {28'd0, bus.o_idu_valid, bus.o_exu_valid, bus.o_lsu_valid, bus.o_wbu_valid}, 32'd0);
    check("arst_cnts", {bus.o_stall_cnt, bus.o_flush_cnt}, 32'd0);
    check("arst_en", {26'd0, bus.o_pc_we, bus.o_pc_sel_jmp, bus.o_i2i_en, bus.o_i2e_en,
                      bus.o_e2l_en, bus.o_l2w_en}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1); run(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central sequencer for the five-stage core pipeline (IFU → IDU → EXU → LSU → WBU). It owns the per-stage valid bits and drives the load enables of the inter-stage registers (ifu→idu, idu→exu, exu→lsu, lsu→wbu) and the PC register. It resolves three events each cycle: LSU-busy freeze, taken-jump flush from EXU, and load-use hazard stall. It also keeps saturating stall and flush performance counters.

## Interface
- CNT_WIDTH, 16, width of each performance counter
- REG_ID_WIDTH, 5, width of register-index fields
- i_sys_clk  in  1  core clock; all state updates on its rising edge
- i_sys_rst  in  1  reset, asynchronous, active-high
- i_ifu_valid  in  1  IFU presents a fetched instruction this cycle
- i_idu_rs1_en / i_idu_rs2_en  in  1 each  instruction in IDU reads rs1 / rs2
- i_idu_rs1_id / i_idu_rs2_id  in  REG_ID_WIDTH each  source register indices in IDU
- i_exu_load  in  1  instruction in EXU is a load
- i_exu_rd_id  in  REG_ID_WIDTH  destination register index in EXU
- i_exu_jmp_en  in  1  instruction in EXU is a taken branch/jump
- i_lsu_busy  in  1  LSU memory access not complete this cycle
- o_pc_we  out  1  PC register load enable
- o_pc_sel_jmp  out  1  PC mux select: 1 = EXU jump target, 0 = sequential
- o_i2i_en / o_i2e_en / o_e2l_en / o_l2w_en  out  1 each  inter-stage register load enables
- o_idu_valid / o_exu_valid / o_lsu_valid / o_wbu_valid  out  1 each  stage holds a live instruction
- o_stall_cnt  out  CNT_WIDTH  cycles spent in FREEZE or HAZARD
- o_flush_cnt  out  CNT_WIDTH  number of FLUSH cycles

## Operation
- State: registers v_idu, v_exu, v_lsu, v_wbu, plus the two counters.
- Per-cycle event terms, evaluated combinationally from the current state:
  - freeze = v_lsu & i_lsu_busy
  - flush = v_exu & i_exu_jmp_en
  - hazard = v_idu & v_exu & i_exu_load & (i_exu_rd_id != 0) & ((i_idu_rs1_en & rs1 == rd) | (i_idu_rs2_en & rs2 == rd))
- The cycle mode is chosen by strict priority: FREEZE > FLUSH > HAZARD > RUN.
- FREEZE:
  - All enables are 0 and o_pc_we is 0.
  - v_idu, v_exu and v_lsu hold; v_wbu <= 0 (bubble into WBU).
- FLUSH:
  - o_pc_we = 1, o_pc_sel_jmp = 1; all four stage enables are 1.
  - v_idu <= 0, v_exu <= 0, v_lsu <= 1 (the jump proceeds), v_wbu <= v_lsu.
  - The wrong-path instruction in IDU and the fetch in flight are both discarded.
- HAZARD:
  - o_pc_we = 0, o_i2i_en = 0, o_i2e_en = 0; o_e2l_en = 1, o_l2w_en = 1.
  - v_idu holds; v_exu <= 0 (bubble); v_lsu <= v_exu; v_wbu <= v_lsu.
- RUN:
  - o_pc_we = i_ifu_valid, o_pc_sel_jmp = 0; all stage enables are 1.
  - v_idu <= i_ifu_valid, v_exu <= v_idu, v_lsu <= v_exu, v_wbu <= v_lsu.
- o_pc_sel_jmp is 0 in every mode other than FLUSH.
- Counters:
  - o_stall_cnt increments by 1 in each FREEZE or HAZARD cycle.
  - o_flush_cnt increments by 1 in each FLUSH cycle.
  - Both saturate at all-ones and never wrap.
- Register index 0 never creates a hazard.

## Timing
- Reset:
  - While i_sys_rst is high, all valids and counters are 0.
  - While i_sys_rst is high, o_pc_we and all stage enables are forced to 0, and o_pc_sel_jmp = 0.
  - Assertion mid-operation kills all in-flight instructions immediately, without waiting for a clock edge.
- First edge after reset deasserts: RUN mode; the pipeline fills one stage per cycle.
- Outputs:
  - o_*_valid and counters are registered, and change one cycle after the event.
  - Enables and PC controls are combinational from current state and inputs, valid in the same cycle.
- Latency:
  - A HAZARD inserts exactly one bubble, because the load leaves EXU on that edge.
  - A FLUSH costs two bubbles (IDU and EXU slots).
  - A FREEZE lasts for as many cycles as i_lsu_busy stays high with v_lsu = 1.
- Simultaneous events:
  - i_lsu_busy together with a jump in EXU: FREEZE wins, and the flush is taken on the first non-busy cycle.
  - A jump together with a hazard: FLUSH wins.
  - i_lsu_busy with v_lsu = 0 is ignored.

## Test plan
- Reset and fill: pulse i_sys_rst, then hold i_ifu_valid = 1 → o_idu_valid..o_wbu_valid rise on consecutive cycles 1..4; counters stay 0.
- Load-use stall: EXU holds a load with rd = 5, IDU reads rs1 = 5 → one cycle with o_pc_we = 0, o_i2i_en = 0, o_i2e_en = 0; next cycle o_exu_valid = 0; o_stall_cnt = 1. Repeat with rd = 0 → no stall.
- Taken jump: i_exu_jmp_en = 1 with v_exu = 1 → o_pc_sel_jmp = 1 and o_pc_we = 1; next cycle o_idu_valid = 0, o_exu_valid = 0, o_lsu_valid = 1; o_flush_cnt = 1.
- LSU freeze: i_lsu_busy high for 3 cycles with v_lsu = 1 → all enables 0 for 3 cycles; o_wbu_valid = 0 for those cycles; IDU/EXU/LSU valids unchanged; o_stall_cnt += 3.
- Priority: assert i_lsu_busy and a jump together for 2 cycles, then drop busy → 2 FREEZE cycles, then exactly one FLUSH cycle; o_flush_cnt = 1.
- Saturation and async reset: force o_stall_cnt to 0xFFFF via a long freeze → stays at 0xFFFF. Then assert i_sys_rst between clock edges → valids, counters and enables read 0 immediately.
